// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits LATENCY
// cycles, commits against a word-addressed array, then holds the response until accepted.
`timescale 1ns/1ps

module dmem_responder #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   input  logic [XLEN/8-1:0]     req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rsp_rdata,
   output logic                  rsp_err
);

   localparam int NBYTES = XLEN / 8;
   localparam int IDXW   = ADDR_WIDTH - 2;
   localparam int DEPTH  = 2 ** IDXW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [IDXW-1:0]     r_idx;
   logic [XLEN-1:0]     r_wdata;
   logic [NBYTES-1:0]   r_be;
   logic                r_misal;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic                r_rsp_load;

   logic [XLEN-1:0]     r_mem [DEPTH];
   logic [XLEN-1:0]     r_mem_q;

   logic                w_commit;

   assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0);

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   // Read register is only meaningful for an aligned load; stores/errors show zero.
   assign rsp_rdata = r_rsp_load ? r_mem_q : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_misal     <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_load  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_idx       <= req_addr[ADDR_WIDTH-1:2];
                  r_wdata     <= req_wdata;
                  r_be        <= req_be;
                  r_misal     <= |req_addr[1:0];
                  r_cnt       <= 4'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= r_misal;
                  r_rsp_load  <= !r_we && !r_misal;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_load  <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   // Array is never reset; reset only blocks a commit that would coincide with it.
   always_ff @(posedge clk) begin
      if (w_commit && !reset && !r_misal) begin
         if (r_we) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (r_be[b]) begin
                  r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
               end
            end
         end else begin
            r_mem_q <= r_mem[r_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table plus hand-written backpressure and reset
// sequences, with expected responses queued at issue and popped on rsp_valid.
`timescale 1ns/1ps

module tb_dmem_responder;

   localparam int XLEN  = 32;
   localparam int AW    = 8;
   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [3:0]      req_be;
   logic            rsp_ready;
   logic            sel;

   logic            a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
   logic [XLEN-1:0] a_rsp_rdata;
   logic            b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
   logic [XLEN-1:0] b_rsp_rdata;

   logic            o_req_ready, o_rsp_valid, o_rsp_err;
   logic [XLEN-1:0] o_rsp_rdata;

   always #5 clk = ~clk;

   assign a_req_valid = req_valid & ~sel;
   assign b_req_valid = req_valid & sel;
   assign o_req_ready = sel ? b_req_ready : a_req_ready;
   assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

   dmem_responder #(.XLEN(XLEN), .ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .req_valid (a_req_valid),
      .req_ready (a_req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (a_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (a_rsp_rdata),
      .rsp_err   (a_rsp_err)
   );

   dmem_responder #(.XLEN(XLEN), .ADDR_WIDTH(AW), .LATENCY(LAT_B)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (b_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err)
   );

   int cycle = 0;
   always @(posedge clk) cycle = cycle + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[14];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with the selected DUT idle; returns at the negedge after completion.
   task automatic do_txn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, output int acc_cycle);
      exp_t e;
      int   waited;
      check("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      sb_q.push_back(e);
      @(negedge clk);
      acc_cycle = cycle;
      req_valid = 1'b0;
      check("req_ready_busy", {31'd0, o_req_ready}, 32'd0);
      waited = 0;
      while (!o_rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!o_rsp_valid) begin
         check("rsp_timeout", {31'd0, o_rsp_valid}, 32'd1);
         void'(sb_q.pop_front());
         return;
      end
      check("latency", waited, lat);
      e = sb_q.pop_front();
      check("rsp_rdata", o_rsp_rdata, e.rdata);
      check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
      $display("txn we=%0b addr=0x%02h wdata=0x%08h be=0x%h -> rdata=0x%08h err=%0b lat=%0d",
               we, addr, wdata, be, o_rsp_rdata, o_rsp_err, waited);
      @(negedge clk);
      check("rsp_valid_drop", {31'd0, o_rsp_valid}, 32'd0);
   endtask

   initial begin
      int   acc;
      int   prev;
      int   waited;
      exp_t e;

      vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b1, 8'h22, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[6]  = '{1'b0, 8'h22, 32'h0,        4'h0, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[8]  = '{1'b1, 8'h00, 32'h00000001, 4'hF, 32'h0,        1'b0};
      vecs[9]  = '{1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 8'hFC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h00000001, 1'b0};
      vecs[12] = '{1'b0, 8'h21, 32'h0,        4'h0, 32'h0,        1'b1};
      vecs[13] = '{1'b1, 8'h00, 32'h0000FF00, 4'h2, 32'h0,        1'b0};

      sel       = 1'b0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b1;

      // Reset values must appear before any clock edge.
      #1;
      check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      prev = 0;
      for (int i = 0; i < 14; i++) begin
         do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].rdata, vecs[i].err, LAT_A, acc);
         if (i > 0) check("spacing", acc - prev, LAT_A + 2);
         prev = acc;
      end
      do_txn(1'b0, 8'h00, 32'h0, 4'h0, 32'h0000FF01, 1'b0, LAT_A, acc);

      // Backpressure: response held for 5 cycles while a competing store is offered.
      req_we    = 1'b0;
      req_addr  = 8'h10;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      e.rdata   = 32'hDEADBEEF;
      e.err     = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      waited = 0;
      while (!o_rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("bp_latency", waited, LAT_A);
      e = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
         check("bp_rsp_rdata", o_rsp_rdata, e.rdata);
         check("bp_rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
         check("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
         $display("bp cycle %0d: rsp_valid=%0b rdata=0x%08h req_ready=%0b",
                  k, o_rsp_valid, o_rsp_rdata, o_req_ready);
         req_we    = 1'b1;
         req_addr  = 8'h10;
         req_wdata = 32'h0;
         req_be    = 4'hF;
         req_valid = 1'b1;
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      check("bp_hold_rdata", o_rsp_rdata, e.rdata);
      @(negedge clk);
      check("bp_done_valid", {31'd0, o_rsp_valid}, 32'd0);
      check("bp_done_ready", {31'd0, o_req_ready}, 32'd1);
      do_txn(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, LAT_A, acc);

      // Reset while a load response is pending: outputs clear at once, no stale response.
      req_we    = 1'b0;
      req_addr  = 8'h20;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      waited = 0;
      while (!o_rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("rr_pending_rdata", o_rsp_rdata, 32'h11BB33DD);
      reset = 1'b1;
      #1;
      check("rr_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      check("rr_rsp_rdata", o_rsp_rdata, 32'd0);
      check("rr_req_ready", {31'd0, o_req_ready}, 32'd1);
      @(negedge clk);
      reset     = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rr_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
      end

      // Reset during WAIT on the LATENCY=3 instance drops the uncommitted store.
      sel = 1'b1;
      @(negedge clk);
      do_txn(1'b1, 8'h30, 32'h0, 4'hF, 32'h0, 1'b0, LAT_B, acc);
      req_we    = 1'b1;
      req_addr  = 8'h30;
      req_wdata = 32'h12345678;
      req_be    = 4'hF;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("rw_busy", {31'd0, o_req_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rw_req_ready", {31'd0, o_req_ready}, 32'd1);
      check("rw_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rw_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
      end
      do_txn(1'b0, 8'h30, 32'h0, 4'h0, 32'h0, 1'b0, LAT_B, acc);
      do_txn(1'b1, 8'h30, 32'h0BADF00D, 4'hC, 32'h0, 1'b0, LAT_B, acc);
      do_txn(1'b0, 8'h30, 32'h0, 4'h0, 32'h0BAD0000, 1'b0, LAT_B, acc);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, default 32, data width in bits; XLEN SHALL be 32.
REQ-002 Parameter ADDR_WIDTH, default 8, byte-address width; depth SHALL be 2^(ADDR_WIDTH-2) words.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to commit; legal range SHALL be 1..15.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata  input  XLEN  store data.
REQ-011 req_be  input  XLEN/8  store byte enables; bit i SHALL gate byte i.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  XLEN  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned access (req_addr[1:0] != 0).

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-017 IDLE: req_ready=1 and rsp_valid=0; req_ready SHALL be 0 in WAIT and RESP.
REQ-018 Handshake SHALL occur on a rising edge with req_valid=1 and req_ready=1; we, addr, wdata and be SHALL be latched at that edge; FSM->WAIT; wait counter loads LATENCY-1.
REQ-019 Request inputs SHALL be ignored outside IDLE.
REQ-020 WAIT: on each edge with counter != 0, the counter SHALL decrement; on the edge with counter == 0, the access SHALL commit and FSM->RESP.
REQ-021 Commit, aligned store: each memory byte i SHALL be written with wdata byte i where be[i]=1, other bytes unchanged; rsp_rdata=0, rsp_err=0.
REQ-022 Commit, aligned load: rsp_rdata SHALL be the word at req_addr[ADDR_WIDTH-1:2]; rsp_err=0.
REQ-023 Commit, misaligned access: memory SHALL remain unmodified; rsp_rdata=0, rsp_err=1.
REQ-024 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-025 RESP: the edge with rsp_ready=1 SHALL complete the transaction, FSM->IDLE.
REQ-026 Latency: for acceptance at edge N, rsp_valid SHALL rise right after edge N+LATENCY; minimum request spacing SHALL be LATENCY+2 cycles.
REQ-027 Load of a word stored earlier SHALL return the stored data (read-after-write through the array; no forwarding is needed because only one transaction is outstanding).
REQ-028 Address wrap: word index SHALL use req_addr[ADDR_WIDTH-1:2] only; no out-of-range error.

Reset
REQ-029 While reset=1: FSM=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, effective immediately without a clock edge.
REQ-030 The memory array SHALL NOT be cleared by reset; contents after power-up are undefined.
REQ-031 Reset in WAIT SHALL drop the pending access; an uncommitted store SHALL NOT modify memory.
REQ-032 Reset in RESP SHALL discard the response; no rsp_valid SHALL follow reset deassertion until a new handshake.

Verification
REQ-033 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF, rsp_ready=1 -> rsp_valid high in 1 cycle starting 2 edges after acceptance, rsp_rdata=0, rsp_err=0; then load 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-034 Partial store: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD with be 0x5 -> load 0x20 returns 0x11BB33DD.
REQ-035 Misaligned: store 0x22 with be 0xF, then load 0x22 -> both responses rsp_err=1, rsp_rdata=0; aligned load of 0x20 unchanged.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, new req_valid ignored; completes the cycle after rsp_ready=1.
REQ-037 Reset mid-op: store 0x30 = 0x12345678 over 0x0 with LATENCY=3; assert reset 1 edge after acceptance -> req_ready=1 and rsp_valid=0 at once; later load 0x30 returns 0x0.
REQ-038 Wrap: ADDR_WIDTH=8; store 0xFC = 0xCAFEF00D -> load 0xFC returns 0xCAFEF00D; back-to-back requests are accepted every LATENCY+2 cycles.
